fdiv_pipe: RTL and testbench

Fully pipelined single-precision divider stage that sits directly downstream of finv and computes q = x / y as x * finv(y).
- Drives the divisor into an external finv instance.
- Delays the dividend, valid and special-case tags by finv's fixed latency.
- Multiplies the dividend by the returned reciprocal in an internal 2-stage multiplier.
- Accepts one operation per cycle, with no backpressure.

---
 rtl/fpu_pkg.sv | 27 ++
 rtl/fmul_core.sv | 55 +++++
 rtl/fdiv_pipe.sv | 85 ++++++++
 tb/tb_fdiv_pipe.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared binary32 types, constants and operand classification for the FPU datapath
package fpu_pkg;
  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
  } float32_t;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX = 255;
  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fclass_e;
  typedef struct packed {
    fclass_e cx;
    fclass_e cy;
    logic    sy;
  } tag_t;
  typedef struct packed {
    logic        spec;
    logic        dz;
    logic        inv;
    logic [31:0] q;
  } spec_t;
  function automatic fclass_e fclass(float32_t f, logic flush);
    return f.e == 8'd0 ? (flush || f.m == 23'd0 ? ZERO : NORM) :
           f.e != 8'(EXP_MAX) ? NORM : f.m == 23'd0 ? INF : NAN;
  endfunction
endpackage

// File: rtl/fmul_core.sv
// fmul_core: 2-stage binary32 multiply for normal operands (M1 product/exponent, M2 normalise/RNE/range); clk, rstn, in_valid, a, b -> out_valid, p, ovf
module fmul_core
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  input  float32_t    a,
  input  float32_t    b,
  output logic        out_valid,
  output logic [31:0] p,
  output logic        ovf
);
  localparam logic signed [9:0] EMAX = 10'(EXP_MAX);
  logic v1, s1, norm, g, st;
  logic [47:0] prod;
  logic signed [9:0] e1, en;
  logic [23:0] m24;
  logic [24:0] sum;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      v1 <= 1'b0;
      s1 <= 1'b0;
      prod <= '0;
      e1 <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        s1 <= a.s ^ b.s;
        prod <= 48'({1'b1, a.m}) * 48'({1'b1, b.m});
        e1 <= 10'(a.e) + 10'(b.e) - 10'(EXP_BIAS);
      end
    end
  always_comb begin
    norm = prod[47];
    m24 = norm ? prod[47:24] : prod[46:23];
    g = norm ? prod[23] : prod[22];
    st = norm ? |prod[22:0] : |prod[21:0];
    sum = {1'b0, m24} + 25'(g & (st | m24[0]));
    en = e1 + 10'(norm) + 10'(sum[24]);
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      out_valid <= 1'b0;
      p <= '0;
      ovf <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        ovf <= en >= EMAX;
        p <= en >= EMAX ? {s1, 8'hFF, 23'd0} : en <= 10'sd0 ? {s1, 31'd0} :
             {s1, en[7:0], sum[24] ? sum[23:1] : sum[22:0]};
      end
    end
endmodule

// File: rtl/fdiv_pipe.sv
// fdiv_pipe: pipelined q = x * finv(y); y -> finv_x, finv_y back after FINV_LAT, out after FINV_LAT+2 with q/dz/inv/ovf, busy = ops in flight
module fdiv_pipe
  import fpu_pkg::*;
#(
  parameter int FINV_LAT = 4,
  parameter int FLUSH_DENORM = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] finv_x,
  input  logic [31:0] finv_y,
  output logic        out_valid,
  output logic [31:0] q,
  output logic        flag_dz,
  output logic        flag_inv,
  output logic        flag_ovf,
  output logic        busy
);
  localparam int CW = $clog2(FINV_LAT + 3);
  localparam logic FLUSH = FLUSH_DENORM != 0;
  logic dv [FINV_LAT];
  logic [31:0] dx [FINV_LAT];
  tag_t dt [FINV_LAT];
  tag_t t;
  spec_t sr, s1, s2;
  logic sg, pv1, movf;
  logic [31:0] mq;
  logic [CW-1:0] cnt;
  assign finv_x = y;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      for (int i = 0; i < FINV_LAT; i++) begin
        dv[i] <= 1'b0;
        dx[i] <= '0;
        dt[i] <= '0;
      end
    end else begin
      dv[0] <= in_valid;
      dx[0] <= x;
      dt[0] <= '{cx: fclass(x, FLUSH), cy: fclass(y, FLUSH), sy: y[31]};
      for (int i = 1; i < FINV_LAT; i++) begin
        dv[i] <= dv[i-1];
        dx[i] <= dx[i-1];
        dt[i] <= dt[i-1];
      end
    end
  always_comb begin
    t = dt[FINV_LAT-1];
    sg = dx[FINV_LAT-1][31] ^ t.sy;
    sr.inv = t.cx == NAN || t.cy == NAN || (t.cx == ZERO && t.cy == ZERO) || (t.cx == INF && t.cy == INF);
    sr.dz = !sr.inv && t.cy == ZERO;
    sr.spec = t.cx != NORM || t.cy != NORM;
    sr.q = sr.inv ? QNAN : sr.dz || t.cx == INF ? {sg, 8'hFF, 23'd0} : {sg, 31'd0};
  end
  fmul_core u_mul (
    .clk(clk),
    .rstn(rstn),
    .in_valid(dv[FINV_LAT-1]),
    .a(dx[FINV_LAT-1]),
    .b(finv_y),
    .out_valid(out_valid),
    .p(mq),
    .ovf(movf)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      pv1 <= 1'b0;
      s1 <= '0;
      s2 <= '0;
      cnt <= '0;
    end else begin
      pv1 <= dv[FINV_LAT-1];
      if (dv[FINV_LAT-1]) s1 <= sr;
      if (pv1) s2 <= s1;
      cnt <= cnt + CW'(in_valid) - CW'(out_valid);
    end
  assign q = s2.spec ? s2.q : mq;
  assign flag_dz = s2.dz;
  assign flag_inv = s2.inv;
  assign flag_ovf = !s2.spec && movf;
  assign busy = cnt != '0;
endmodule

// File: tb/tb_fdiv_pipe.sv
// tb_fdiv_pipe: directed and random scoreboard bench for fdiv_pipe against a real-arithmetic reference
module tb_fdiv_pipe;
  localparam int L = 4;
  localparam int N = 4096;
  typedef struct packed {
    logic [31:0] q;
    logic dz, inv, ovf;
  } res_t;
  logic clk = 0, rstn = 0, in_valid = 0;
  logic [31:0] x = 0, y = 0, finv_y = 0, finv_x, q;
  logic out_valid, flag_dz, flag_inv, flag_ovf, busy;
  int errors = 0, checks = 0, cyc = 0;
  logic iva [N];
  logic ulpa [N];
  logic [31:0] xa [N], ya [N], ra [N];
  logic [31:0] sp [7];
  res_t last;
  always #5 clk = ~clk;
  fdiv_pipe #(.FINV_LAT(L), .FLUSH_DENORM(1)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .x(x), .y(y),
    .finv_x(finv_x), .finv_y(finv_y), .out_valid(out_valid), .q(q),
    .flag_dz(flag_dz), .flag_inv(flag_inv), .flag_ovf(flag_ovf), .busy(busy)
  );
  function automatic real f2r(logic [31:0] f);
    return f[30:23] == 8'd0 ? 0.0 : $bitstoreal({f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0});
  endfunction
  function automatic logic [32:0] d2f(real v);
    logic [63:0] b;
    int e;
    logic [24:0] m;
    b = $realtobits(v);
    if (v == 0.0) return {1'b0, b[63], 31'd0};
    e = int'(b[62:52]) - 896;
    m = {2'b01, b[51:29]};
    if (b[28:0] > 29'h1000_0000 || (b[28:0] == 29'h1000_0000 && m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {1'b1, b[63], 8'hFF, 23'd0};
    if (e <= 0) return {1'b0, b[63], 31'd0};
    return {1'b0, b[63], 8'(e), m[22:0]};
  endfunction
  function automatic logic [31:0] recip(logic [31:0] d);
    logic [32:0] r;
    r = d2f(1.0 / f2r(d));
    return r[31:0];
  endfunction
  function automatic res_t model(logic [31:0] a, logic [31:0] d, logic [31:0] r);
    logic s, az, ai, an, dz0, di, dn;
    logic [32:0] p;
    s = a[31] ^ d[31];
    az = a[30:23] == 8'd0;
    ai = a[30:23] == 8'hFF && a[22:0] == 23'd0;
    an = a[30:23] == 8'hFF && a[22:0] != 23'd0;
    dz0 = d[30:23] == 8'd0;
    di = d[30:23] == 8'hFF && d[22:0] == 23'd0;
    dn = d[30:23] == 8'hFF && d[22:0] != 23'd0;
    if (an || dn || (az && dz0) || (ai && di)) return '{32'h7FC00000, 1'b0, 1'b1, 1'b0};
    if (dz0) return '{{s, 8'hFF, 23'd0}, 1'b1, 1'b0, 1'b0};
    if (ai) return '{{s, 8'hFF, 23'd0}, 1'b0, 1'b0, 1'b0};
    if (di || az) return '{{s, 31'd0}, 1'b0, 1'b0, 1'b0};
    p = d2f(f2r(a) * f2r(r));
    return '{p[31:0], 1'b0, 1'b0, p[32]};
  endfunction
  function automatic logic [31:0] rnd_norm();
    return {1'($urandom), 8'($urandom_range(184, 70)), 23'($urandom)};
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(logic v, logic [31:0] a, logic [31:0] d, logic [31:0] r, logic u);
    int k;
    bit ev, eb;
    @(negedge clk);
    rstn = 1;
    k = cyc - L - 2;
    ev = k >= 0 && iva[k];
    if (ev) last = model(xa[k], ya[k], ra[k]);
    eb = 0;
    for (int j = (k < 0 ? 0 : k); j < cyc; j++) eb |= iva[j];
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("q", q, last.q);
    chk("flags", 32'({flag_dz, flag_inv, flag_ovf}), 32'({last.dz, last.inv, last.ovf}));
    chk("busy", 32'(busy), 32'(eb));
    if (cyc > 0) chk("finv_x", finv_x, ya[cyc-1]);
    if (ev && ulpa[k]) begin
      logic [32:0] rf;
      int df;
      rf = d2f(f2r(xa[k]) / f2r(ya[k]));
      df = int'(q[30:0]) - int'(rf[30:0]);
      checks++;
      assert (q[31] == rf[31] && df >= -1 && df <= 1) else begin
        errors++;
        $error("FAIL ulp got=%h exp=%h", q, rf[31:0]);
      end
    end
    iva[cyc] = v;
    xa[cyc] = a;
    ya[cyc] = d;
    ra[cyc] = r;
    ulpa[cyc] = u;
    in_valid = v;
    x = a;
    y = d;
    finv_y = cyc >= L ? ra[cyc-L] : 32'd0;
    cyc++;
  endtask
  task automatic lit(string tag, logic [31:0] eq, logic [2:0] ef);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_q"}, q, eq);
    chk({tag, "_flags"}, 32'({flag_dz, flag_inv, flag_ovf}), 32'(ef));
  endtask
  task automatic idle(int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask
  task automatic mid_reset();
    @(negedge clk);
    rstn = 0;
    in_valid = 0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q", q, 32'd0);
    chk("rst_flags", 32'({flag_dz, flag_inv, flag_ovf}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    for (int j = 0; j <= cyc; j++) iva[j] = 0;
    xa[cyc] = x;
    ya[cyc] = y;
    ra[cyc] = 0;
    ulpa[cyc] = 0;
    last = '0;
    cyc++;
  endtask
  initial begin
    logic [31:0] a, d;
    for (int i = 0; i < N; i++) begin
      iva[i] = 0;
      ulpa[i] = 0;
      xa[i] = 0;
      ya[i] = 0;
      ra[i] = 0;
    end
    sp = '{32'h0, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00001, 32'h3F800000, 32'hC0400000};
    last = '0;
    @(posedge clk);
    #1;
    chk("init_out_valid", 32'(out_valid), 32'd0);
    chk("init_q", q, 32'd0);
    chk("init_flags", 32'({flag_dz, flag_inv, flag_ovf}), 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    step(1, 32'h40C00000, 32'h40000000, 32'h3F000000, 0);
    idle(L + 2);
    lit("exact", 32'h40400000, 3'b000);
    step(1, 32'h3F800000, 32'h00000000, 32'h0, 0);
    step(1, 32'h00000000, 32'h00000000, 32'h0, 0);
    idle(L + 1);
    lit("dz", 32'h7F800000, 3'b100);
    idle(1);
    lit("inv00", 32'h7FC00000, 3'b010);
    step(1, 32'h7F000000, 32'h3E800000, 32'h40800000, 0);
    idle(L + 2);
    lit("ovf", 32'h7F800000, 3'b001);
    step(1, 32'h3FFFFFFF, 32'h3F7FFFFE, 32'h3F800001, 0);
    idle(L + 2);
    lit("tie", 32'h40000000, 3'b000);
    for (int i = 0; i < 60; i++) begin
      a = $urandom_range(3) == 0 ? rnd_norm() : sp[$urandom_range(6)];
      d = $urandom_range(3) == 0 ? rnd_norm() : sp[$urandom_range(6)];
      step(1, a, d, d[30:23] != 8'd0 && d[30:23] != 8'hFF ? recip(d) : 32'h0, 0);
    end
    idle(L + 2);
    for (int i = 0; i < 1000; i++) begin
      if (i % 7 == 6) idle(1);
      else begin
        a = rnd_norm();
        d = rnd_norm();
        step(1, a, d, recip(d), 1);
      end
    end
    idle(L + 2);
    for (int i = 0; i < 3; i++) begin
      d = rnd_norm();
      step(1, rnd_norm(), d, recip(d), 1);
    end
    mid_reset();
    idle(L + 4);
    d = rnd_norm();
    step(1, 32'h40C00000, 32'h40000000, 32'h3F000000, 0);
    idle(L + 2);
    lit("post_rst", 32'h40400000, 3'b000);
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
